// File: rtl/hazard_scoreboard.sv
// Shift-register hazard scoreboard: ID stall plus registered EX bypass selects.
// Define STALL_CNT_EN to add a saturating stall_count output.
module hazard_scoreboard #(
   parameter int REG_ADDR_W = 5,
   parameter int DEPTH      = 3,
   parameter int SEL_W      = 2
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  en,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic [SEL_W-1:0]      id_ready_stage,
   input  logic                  flush,
   output logic                  stall,
   output logic                  issue,
   output logic [SEL_W-1:0]      fwd_sel_a,
   output logic [SEL_W-1:0]      fwd_sel_b
`ifdef STALL_CNT_EN
   ,
   output logic [31:0]           stall_count
`endif
);

   logic [DEPTH-1:0]      e_valid;
   logic [DEPTH-1:0]      e_wr;
   logic [REG_ADDR_W-1:0] e_rd  [DEPTH];
   logic [SEL_W-1:0]      e_rdy [DEPTH];

   logic [DEPTH-1:0] hit_a;
   logic [DEPTH-1:0] hit_b;
   logic [SEL_W-1:0] sel_a;
   logic [SEL_W-1:0] sel_b;
   logic             haz_a;
   logic             haz_b;

   // r0 is never a real dependency, so a zero source can never hit.
   for (genvar k = 0; k < DEPTH; k++) begin : g_hit
      assign hit_a[k] = e_valid[k] & e_wr[k] & id_uses_rs &
                        (e_rd[k] == id_rs) & (id_rs != '0);
      assign hit_b[k] = e_valid[k] & e_wr[k] & id_uses_rt &
                        (e_rd[k] == id_rt) & (id_rt != '0);
   end

   // Scan oldest to youngest so the youngest producer overwrites.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      haz_a = 1'b0;
      haz_b = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (hit_a[k]) begin
            sel_a = SEL_W'(k + 1);
            haz_a = (e_rdy[k] > SEL_W'(k + 1));
         end
         if (hit_b[k]) begin
            sel_b = SEL_W'(k + 1);
            haz_b = (e_rdy[k] > SEL_W'(k + 1));
         end
      end
   end

   assign stall = id_valid & ~flush & (haz_a | haz_b);
   assign issue = id_valid & ~stall & ~flush;

   always_ff @(posedge clk) begin
      if (srst) begin
         e_valid   <= '0;
         e_wr      <= '0;
         fwd_sel_a <= '0;
         fwd_sel_b <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            e_rd[k]  <= '0;
            e_rdy[k] <= '0;
         end
      end else if (en) begin
         e_valid[0] <= issue;
         e_wr[0]    <= id_reg_write;
         e_rd[0]    <= id_rd;
         e_rdy[0]   <= id_ready_stage;
         // A flush kills entry 0 before it moves into entry 1.
         for (int k = 1; k < DEPTH; k++) begin
            e_valid[k] <= (k == 1 && flush) ? 1'b0 : e_valid[k-1];
            e_wr[k]    <= e_wr[k-1];
            e_rd[k]    <= e_rd[k-1];
            e_rdy[k]   <= e_rdy[k-1];
         end
         fwd_sel_a <= issue ? sel_a : '0;
         fwd_sel_b <= issue ? sel_b : '0;
      end
   end

`ifdef STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (srst) begin
         stall_count <= '0;
      end else if (en && stall && stall_count != '1) begin
         stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven bench for hazard_scoreboard with a queue of expected selects.
// Build with STALL_CNT_EN defined to also check stall_count.
module tb_hazard_scoreboard;

   logic       clk;
   logic       srst;
   logic       en;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rs;
   logic       id_uses_rt;
   logic [4:0] id_rd;
   logic       id_reg_write;
   logic [1:0] id_ready_stage;
   logic       flush;
   logic       stall;
   logic       issue;
   logic [1:0] fwd_sel_a;
   logic [1:0] fwd_sel_b;
`ifdef STALL_CNT_EN
   logic [31:0] stall_count;
`endif

   hazard_scoreboard dut (
      .clk            (clk),
      .srst           (srst),
      .en             (en),
      .id_valid       (id_valid),
      .id_rs          (id_rs),
      .id_rt          (id_rt),
      .id_uses_rs     (id_uses_rs),
      .id_uses_rt     (id_uses_rt),
      .id_rd          (id_rd),
      .id_reg_write   (id_reg_write),
      .id_ready_stage (id_ready_stage),
      .flush          (flush),
      .stall          (stall),
      .issue          (issue),
      .fwd_sel_a      (fwd_sel_a),
      .fwd_sel_b      (fwd_sel_b)
`ifdef STALL_CNT_EN
      ,
      .stall_count    (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int srst, en, fl, v;
      int rs, rt, urs, urt;
      int rd, rw, rdy;
      int st, is, sa, sb, cnt;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   tests;
   int   fails;
   int   row;

   function automatic vec_t mk(int srst_i, int en_i, int fl, int v,
                               int rs, int rt, int urs, int urt,
                               int rd, int rw, int rdy,
                               int st, int is, int sa, int sb, int cnt);
      vec_t r;
      r.srst = srst_i; r.en = en_i; r.fl = fl; r.v = v;
      r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
      r.rd = rd; r.rw = rw; r.rdy = rdy;
      r.st = st; r.is = is; r.sa = sa; r.sb = sb; r.cnt = cnt;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input int expv);
      tests++;
      if (act !== 32'(expv)) begin
         fails++;
         $display("FAIL row %0d %s: got %0d expected %0d",
                  row, name, act, expv);
      end
   endtask

   // Drive one ID cycle, check combinational outputs, then the
   // registered selects after the clock edge.
   task automatic cyc(input vec_t v);
      vec_t e;
      srst           = v.srst[0];
      en             = v.en[0];
      flush          = v.fl[0];
      id_valid       = v.v[0];
      id_rs          = 5'(v.rs);
      id_rt          = 5'(v.rt);
      id_uses_rs     = v.urs[0];
      id_uses_rt     = v.urt[0];
      id_rd          = 5'(v.rd);
      id_reg_write   = v.rw[0];
      id_ready_stage = 2'(v.rdy);
      #1;
      chk("stall", 32'(stall), v.st);
      chk("issue", 32'(issue), v.is);
      exp_q.push_back(v);
      @(negedge clk);
      e = exp_q.pop_front();
      chk("fwd_sel_a", 32'(fwd_sel_a), e.sa);
      chk("fwd_sel_b", 32'(fwd_sel_b), e.sb);
`ifdef STALL_CNT_EN
      chk("stall_count", stall_count, e.cnt);
`endif
      row++;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      row   = 1;
      srst = 1'b1; en = 1'b1; flush = 1'b0; id_valid = 1'b0;
      id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
      id_rd = '0; id_reg_write = 1'b0; id_ready_stage = '0;

      //                srst en fl v  rs rt us ut rd rw rdy  st is sa sb cnt
      tbl.push_back(mk(1, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 1,  5, 6, 1, 1,  0, 0, 1,  0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 1,  1, 2, 1, 1,  5, 1, 1,  0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 1,  5, 6, 1, 1,  7, 1, 1,  0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0, 1,  0, 0, 1, 0,  8, 1, 2,  0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 1,  1, 8, 1, 1,  9, 1, 1,  1, 0, 0, 0, 1));
      tbl.push_back(mk(0, 1, 0, 1,  1, 8, 1, 1,  9, 1, 1,  0, 1, 0, 2, 1));
      tbl.push_back(mk(0, 1, 0, 1,  0, 0, 0, 0,  3, 1, 1,  0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 1, 0, 1,  0, 0, 0, 0,  3, 1, 1,  0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 1, 0, 1,  3, 3, 1, 1, 10, 1, 1,  0, 1, 1, 1, 1));
      tbl.push_back(mk(0, 1, 0, 1,  0, 0, 0, 0,  0, 1, 2,  0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 1, 0, 1,  0,10, 1, 0, 11, 1, 1,  0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 1, 0, 1,  0, 0, 0, 0,  8, 1, 2,  0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 1, 1, 1,  8, 0, 1, 0, 12, 1, 1,  0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 1, 0, 1,  8, 0, 1, 0, 13, 1, 1,  0, 1, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 1,  0, 0, 0, 0, 20, 1, 3,  0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 1, 20,20, 1, 1, 21, 1, 1,  1, 0, 0, 0, 1));
      tbl.push_back(mk(0, 1, 0, 1, 20,20, 1, 1, 21, 1, 1,  1, 0, 0, 0, 2));
      tbl.push_back(mk(0, 1, 0, 1, 20,20, 1, 1, 21, 1, 1,  0, 1, 3, 3, 2));
      tbl.push_back(mk(0, 1, 0, 1,  0, 0, 0, 0, 20, 1, 3,  0, 1, 0, 0, 2));
      tbl.push_back(mk(0, 1, 0, 1, 20,20, 1, 1, 21, 1, 1,  1, 0, 0, 0, 3));
      tbl.push_back(mk(1, 1, 0, 1, 20,20, 1, 1, 21, 1, 1,  1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 1, 20,20, 1, 1, 21, 1, 1,  0, 1, 0, 0, 0));

      @(negedge clk);
      foreach (tbl[i]) cyc(tbl[i]);

      // Enable low: state and selects hold, stall stays combinational.
      cyc(mk(0, 1, 0, 1,  0, 0, 0, 0,  5, 1, 2,  0, 1, 0, 0, 0));
      cyc(mk(0, 0, 0, 1,  5, 0, 1, 0,  6, 1, 1,  1, 0, 0, 0, 0));
      cyc(mk(0, 0, 0, 1,  5, 0, 1, 0,  6, 1, 1,  1, 0, 0, 0, 0));
      cyc(mk(0, 1, 0, 1,  5, 0, 1, 0,  6, 1, 1,  1, 0, 0, 0, 1));
      cyc(mk(0, 1, 0, 1,  5, 0, 1, 0,  6, 1, 1,  0, 1, 2, 0, 1));
      cyc(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 2, 0, 1));
      cyc(mk(0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
